// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Data wins by default; a starvation counter and a watchdog bound every wait.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);
    localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic [WW-1:0] wdog, wdog_nxt;
    logic          i_ack_nxt, d_ack_nxt, mem_req_nxt, mem_we_nxt;
    logic          busy_nxt, terr_nxt;
    logic [31:0]   i_rdata_nxt, d_rdata_nxt, addr_nxt, wdata_nxt;
    logic          force_i, finish;
    logic [31:0]   ret_data;

    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        wdog_nxt    = wdog;
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        mem_req_nxt = mem_req;
        mem_we_nxt  = mem_we;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        terr_nxt    = timeout_err;
        force_i     = i_req && (STARVE_LIMIT != 0) && (starve_cnt == SMAX);
        finish      = mem_ack || (wdog == WMAX);
        // Aborts and data-write completions both return zero data
        ret_data    = (mem_ack && !(state == GRANT_D && mem_we)) ? mem_rdata : 32'h0;

        unique case (state)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_nxt   = GRANT_D;
                    mem_req_nxt = 1'b1;
                    mem_we_nxt  = d_we;
                    addr_nxt    = d_addr;
                    wdata_nxt   = d_wdata;
                    wdog_nxt    = '0;
                    if (i_req && starve_cnt != SMAX)
                        starve_nxt = starve_cnt + 1'b1;
                end else if (i_req) begin
                    state_nxt   = GRANT_I;
                    mem_req_nxt = 1'b1;
                    mem_we_nxt  = 1'b0;
                    addr_nxt    = i_addr;
                    wdata_nxt   = 32'h0;
                    wdog_nxt    = '0;
                    starve_nxt  = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                wdog_nxt = wdog + 1'b1;
                if (finish) begin
                    state_nxt   = RELEASE;
                    mem_req_nxt = 1'b0;
                    wdog_nxt    = '0;
                    if (!mem_ack)
                        terr_nxt = 1'b1;
                    if (state == GRANT_D) begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = ret_data;
                    end else begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = ret_data;
                    end
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wdog        <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rdata     <= 32'h0;
            d_rdata     <= 32'h0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_nxt;
            wdog        <= wdog_nxt;
            i_ack       <= i_ack_nxt;
            d_ack       <= d_ack_nxt;
            i_rdata     <= i_rdata_nxt;
            d_rdata     <= d_rdata_nxt;
            mem_req     <= mem_req_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            busy        <= busy_nxt;
            timeout_err <= terr_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random I/D traffic against a transaction-level model,
// plus directed reset, priority, starvation and watchdog scenarios.
module tb_mem_port_arbiter;
    localparam int SL = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_req, mem_we, busy, timeout_err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int total = 0;
    int bad = 0;
    int resp_mode = 2;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    // Transaction-level reference: one access in flight, its age in grant cycles
    bit          m_act = 0, m_isd = 0, m_we = 0, m_rel = 0;
    int          m_age = 0, m_drun = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_v = 0;
    bit          e_iack = 0, e_dack = 0, e_terr = 0;
    logic [31:0] e_irdata = 0, e_drdata = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_rel = 0; m_drun = 0; m_age = 0;
            e_iack = 0; e_dack = 0; e_terr = 0;
            e_irdata = 0; e_drdata = 0;
        end else begin
            e_iack = 0;
            e_dack = 0;
            if (m_act) begin
                m_age++;
                if (mem_ack || m_age == TO) begin
                    m_v = (mem_ack && !(m_isd && m_we)) ? mem_rdata : 32'h0;
                    if (!mem_ack) e_terr = 1;
                    if (m_isd) begin e_dack = 1; e_drdata = m_v; end
                    else begin e_iack = 1; e_irdata = m_v; end
                    m_act = 0;
                    m_rel = 1;
                end
            end else if (m_rel) begin
                m_rel = 0;
            end else if (d_req && !(i_req && SL != 0 && m_drun == SL)) begin
                m_act = 1; m_isd = 1; m_age = 0;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                if (i_req && m_drun < SL) m_drun++;
            end else if (i_req) begin
                m_act = 1; m_isd = 0; m_age = 0;
                m_we = 0; m_addr = i_addr;
                m_drun = 0;
            end
        end
    end

    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            chk1("mem_req", mem_req, m_act);
            chk1("busy", busy, m_act || m_rel);
            chk1("i_ack", i_ack, e_iack);
            chk1("d_ack", d_ack, e_dack);
            chk1("timeout_err", timeout_err, e_terr);
            if (m_act) begin
                chk1("mem_we", mem_we, m_we);
                chk("mem_addr", mem_addr, m_addr);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (e_iack) chk("i_rdata", i_rdata, e_irdata);
            if (e_dack) chk("d_rdata", d_rdata, e_drdata);
        end
    endtask

    // Memory responder: 0 random latency with rare hangs, 1 never acks, 2 acks at once
    logic [31:0] memarr [logic [31:0]];
    bit hang_cur = 0, prev_req = 0;

    initial begin
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 0;
            mem_rdata = $urandom;
            if (!rst_n) begin
                prev_req = 0;
            end else if (mem_req) begin
                if (!prev_req)
                    hang_cur = (resp_mode == 1) ||
                               (resp_mode == 0 && $urandom_range(0, 24) == 0);
                if (!hang_cur && (resp_mode == 2 || $urandom_range(0, 2) == 0)) begin
                    mem_ack = 1;
                    if (mem_we) memarr[mem_addr] = mem_wdata;
                    else mem_rdata = memarr.exists(mem_addr) ? memarr[mem_addr] : ~mem_addr;
                end
            end else if (resp_mode == 0 && $urandom_range(0, 5) == 0) begin
                mem_ack = 1;
            end
            prev_req = rst_n && mem_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int ncyc, output bit got, output bit attr_ok,
                          output bit other);
        ncyc = 0; got = 0; attr_ok = 1; other = 0; rd = 0;
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin i_req = 1; i_addr = addr; end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (mem_req) begin
                ncyc++;
                if (mem_we !== we || mem_addr !== addr) attr_ok = 0;
            end
            if (is_d ? d_ack : i_ack) begin
                got = 1;
                rd = is_d ? d_rdata : i_rdata;
            end
            if (is_d ? i_ack : d_ack) other = 1;
        end
        tick();
        if (is_d) d_req = 0;
        else i_req = 0;
    endtask

    logic [31:0] rd;
    int          nc, first_i, nd, n;
    bit          got, aok, oth, gi, gd, seen_ack;
    logic [9:0]  seq;

    initial begin
        rst_n = 0;
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        fork cmp_loop(); join_none

        // reset
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk1("t1_busy", busy, 1'b0);
        chk1("t1_mem_req", mem_req, 1'b0);
        chk1("t1_acks", i_ack | d_ack, 1'b0);
        chk("t1_mem_addr", mem_addr, 32'h0);
        chk1("t1_err", timeout_err, 1'b0);
        tick();
        rst_n = 1;
        repeat (3) tick();
        chk1("t1_idle_after", busy | mem_req, 1'b0);

        // D write then read back
        resp_mode = 2;
        access(1, 1, 32'h0, 32'h12345678, rd, nc, got, aok, oth);
        chk1("t2_wr_ack", got, 1'b1);
        chk1("t2_wr_attr", aok, 1'b1);
        chk("t2_wr_cycles", nc, 1);
        chk("t2_wr_rdata", rd, 32'h0);
        access(1, 0, 32'h0, 32'h0, rd, nc, got, aok, oth);
        chk1("t2_rd_ack", got, 1'b1);
        chk("t2_rd_rdata", rd, 32'h12345678);

        // both requesters held: D wins four times, then I is forced
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        seq = 0; n = 0; nd = 0; first_i = -1;
        for (int k = 0; k < 400 && n < 10; k++) begin
            @(negedge clk);
            if (d_ack) begin seq = {seq[8:0], 1'b1}; n++; nd++; end
            if (i_ack) begin
                seq = {seq[8:0], 1'b0};
                n++;
                if (first_i < 0) first_i = nd;
            end
        end
        tick();
        i_req = 0;
        d_req = 0;
        chk("t3_order", 32'(seq), 32'(10'b1111011110));
        chk("t3_d_before_i", first_i, 4);

        // I only, data preloaded through D port
        access(1, 1, 32'h4, 32'hCAFE0004, rd, nc, got, aok, oth);
        access(0, 0, 32'h4, 32'h0, rd, nc, got, aok, oth);
        chk1("t4_ack", got, 1'b1);
        chk1("t4_attr", aok, 1'b1);
        chk("t4_rdata", rd, 32'hCAFE0004);
        chk1("t4_no_d_ack", oth, 1'b0);

        // watchdog
        resp_mode = 1;
        access(1, 0, 32'h8, 32'h0, rd, nc, got, aok, oth);
        chk1("t5_ack", got, 1'b1);
        chk("t5_grant_cycles", nc, TO);
        chk("t5_rdata", rd, 32'h0);
        repeat (5) tick();
        chk1("t5_err_sticky", timeout_err, 1'b1);

        // async reset in the middle of a grant
        d_req = 1; d_we = 0; d_addr = 32'hC;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = mem_req;
        end
        chk1("t6_granted", got, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk1("t6_mem_req_drop", mem_req, 1'b0);
        chk1("t6_busy_drop", busy, 1'b0);
        chk1("t6_err_clear", timeout_err, 1'b0);
        d_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        seen_ack = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen_ack = seen_ack | d_ack | i_ack;
        end
        chk1("t6_no_ack", seen_ack, 1'b0);
        chk1("t6_idle", busy | mem_req, 1'b0);

        // random traffic
        resp_mode = 0;
        tick();
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            gi = i_ack;
            gd = d_ack;
            tick();
            if (gi) i_req = ($urandom_range(0, 3) == 0);
            if (gd) d_req = ($urandom_range(0, 3) == 0);
            if (!i_req && $urandom_range(0, 3) == 0) i_req = 1;
            if (!d_req && $urandom_range(0, 2) == 0) d_req = 1;
            if (gi || (i_req && !busy && !mem_req && !m_act))
                i_addr = 32'($urandom_range(0, 15)) << 2;
            if (gd || (d_req && !busy && !mem_req && !m_act)) begin
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
        end

        // drain: no new requests, drop each one once acked
        for (int k = 0; k < 600 && (i_req || d_req || busy); k++) begin
            @(negedge clk);
            gi = i_ack;
            gd = d_ack;
            tick();
            if (gi) i_req = 0;
            if (gd) d_req = 0;
        end
        repeat (3) tick();
        chk1("drain_idle", busy | i_req | d_req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
